// File: rtl/mips_defs.sv
// ============================================================================
//  Module      : mips_defs (package)
//  Description : Shared MIPS datapath definitions. Holds the load-size
//                encodings used by the write-back stage and the fixed
//                register indices for link writes and the hard-wired zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    // Load-size field carried down the pipe from decode.
    // Encoding 2'b11 is unused and treated as a full word.
    typedef enum logic [1:0] {
        LOAD_WORD = 2'b00,
        LOAD_HALF = 2'b01,
        LOAD_BYTE = 2'b10
    } loadSize_t;

    localparam int LINK_REG = 31;   // JAL/JALR return-address register ($ra)
    localparam int REG_ZERO = 0;    // hard-wired zero register, never written

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
//  Module      : load_extract
//  Description : Combinational sub-word load extraction. Selects the
//                addressed byte or halfword lane (little-endian) from the raw
//                memory word, sign- or zero-extends it, and flags accesses
//                whose address is not naturally aligned for their size.
//  Ports       : MemData    in  32  raw data-memory word
//                AddrLow    in  2   effective address bits [1:0]
//                LoadSize   in  2   word / half / byte (11 = word)
//                LoadSigned in  1   1 = sign-extend, 0 = zero-extend
//                Data       out 32  extracted, extended load value
//                Misaligned out 1   address not aligned to access size
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extract
    import mips_defs::*;
(
    input  logic [31:0] MemData,
    input  logic [1:0]  AddrLow,
    input  logic [1:0]  LoadSize,
    input  logic        LoadSigned,
    output logic [31:0] Data,
    output logic        Misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane k lives at MemData[8k+7:8k].
    always_comb begin
        w_byte = MemData[7:0];
        case (AddrLow)
            2'd0:    w_byte = MemData[7:0];
            2'd1:    w_byte = MemData[15:8];
            2'd2:    w_byte = MemData[23:16];
            default: w_byte = MemData[31:24];
        endcase
    end

    // Only AddrLow[1] picks the halfword lane; AddrLow[0] set is a misalignment.
    assign w_half = AddrLow[1] ? MemData[31:16] : MemData[15:0];

    always_comb begin
        Data       = MemData;
        Misaligned = |AddrLow;
        case (LoadSize)
            LOAD_BYTE: begin
                Data       = {{24{LoadSigned & w_byte[7]}}, w_byte};
                Misaligned = 1'b0;
            end
            LOAD_HALF: begin
                Data       = {{16{LoadSigned & w_half[15]}}, w_half};
                Misaligned = AddrLow[0];
            end
            default: begin
                // Word (and the unused 2'b11 code): full word, must be 4-byte aligned.
                Data       = MemData;
                Misaligned = |AddrLow;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
//  Module      : writeback_stage
//  Description : MEM/WB pipeline register and write-back select. Captures
//                the memory-stage result, extracts sub-word loads, redirects
//                link writes to $31 and qualifies the register-file write.
//                Also exports a forwarding qualifier and a retire counter.
//  Ports       : clk, rst (async, active-high)
//                Stall, Flush                         stage control
//                InValid .. InWriteReg                memory-stage fields
//                WriteReg, WriteData, RegWriteSignal  register-file write port
//                FwdValid                             bypass qualifier
//                AlignError                           held load misaligned
//                RetireCount                          departed valid instructions
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = mips_defs::LINK_REG,
    parameter int COUNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic                  InRegWrite,
    input  logic                  InMemToReg,
    input  logic                  InLink,
    input  logic [1:0]            InLoadSize,
    input  logic                  InLoadSigned,
    input  logic [1:0]            InAddrLow,
    input  logic [DATA_W-1:0]     InAluResult,
    input  logic [DATA_W-1:0]     InMemData,
    input  logic [DATA_W-1:0]     InPcPlus4,
    input  logic [REG_ADDR_W-1:0] InWriteReg,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  RegWriteSignal,
    output logic                  FwdValid,
    output logic                  AlignError,
    output logic [COUNT_W-1:0]    RetireCount
);

    localparam logic [REG_ADDR_W-1:0] c_LINK_IDX = REG_ADDR_W'(LINK_REG);
    localparam logic [REG_ADDR_W-1:0] c_ZERO_IDX = REG_ADDR_W'(mips_defs::REG_ZERO);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                  r_valid;
    logic                  r_regWrite;
    logic                  r_memToReg;
    logic                  r_link;
    logic [1:0]            r_loadSize;
    logic                  r_loadSigned;
    logic [1:0]            r_addrLow;
    logic [DATA_W-1:0]     r_aluResult;
    logic [DATA_W-1:0]     r_memData;
    logic [DATA_W-1:0]     r_pcPlus4;
    logic [REG_ADDR_W-1:0] r_writeReg;
    logic [COUNT_W-1:0]    r_retireCount;

    // Flush beats Stall: a flushed slot becomes a bubble even while stalled.
    // Bubble fields are cleared so idle outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_regWrite   <= 1'b0;
            r_memToReg   <= 1'b0;
            r_link       <= 1'b0;
            r_loadSize   <= 2'b00;
            r_loadSigned <= 1'b0;
            r_addrLow    <= 2'b00;
            r_aluResult  <= '0;
            r_memData    <= '0;
            r_pcPlus4    <= '0;
            r_writeReg   <= '0;
        end else if (Flush) begin
            r_valid      <= 1'b0;
            r_regWrite   <= 1'b0;
            r_memToReg   <= 1'b0;
            r_link       <= 1'b0;
            r_loadSize   <= 2'b00;
            r_loadSigned <= 1'b0;
            r_addrLow    <= 2'b00;
            r_aluResult  <= '0;
            r_memData    <= '0;
            r_pcPlus4    <= '0;
            r_writeReg   <= '0;
        end else if (!Stall) begin
            r_valid      <= InValid;
            r_regWrite   <= InRegWrite;
            r_memToReg   <= InMemToReg;
            r_link       <= InLink;
            r_loadSize   <= InLoadSize;
            r_loadSigned <= InLoadSigned;
            r_addrLow    <= InAddrLow;
            r_aluResult  <= InAluResult;
            r_memData    <= InMemData;
            r_pcPlus4    <= InPcPlus4;
            r_writeReg   <= InWriteReg;
        end
    end

    // ------------------------------------------------------------------
    // Retire counter: the held instruction departs whenever the stage is
    // not holding, or when a flush pushes it out regardless of Stall.
    // Suppressed and misaligned instructions still count as retired.
    // ------------------------------------------------------------------
    logic w_depart;
    assign w_depart = r_valid & (Flush | ~Stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retireCount <= '0;
        end else if (w_depart) begin
            r_retireCount <= r_retireCount + COUNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output select / qualify (purely from stage registers)
    // ------------------------------------------------------------------
    logic [31:0]           w_loadData;
    logic                  w_misaligned;
    logic [REG_ADDR_W-1:0] w_dest;
    logic [DATA_W-1:0]     w_data;
    logic                  w_alignErr;

    load_extract u_loadExtract (
        .MemData    (r_memData),
        .AddrLow    (r_addrLow),
        .LoadSize   (r_loadSize),
        .LoadSigned (r_loadSigned),
        .Data       (w_loadData),
        .Misaligned (w_misaligned)
    );

    assign w_dest     = r_link ? c_LINK_IDX : r_writeReg;
    assign w_data     = r_link     ? r_pcPlus4  :
                        r_memToReg ? w_loadData : r_aluResult;

    // Only a real, memory-sourced instruction can raise an alignment fault.
    assign w_alignErr = r_valid & r_memToReg & w_misaligned;

    assign WriteReg       = w_dest;
    assign WriteData      = w_data;
    assign AlignError     = w_alignErr;
    assign RegWriteSignal = r_valid & (r_regWrite | r_link) & ~w_alignErr & (w_dest != c_ZERO_IDX);
    assign FwdValid       = RegWriteSignal;
    assign RetireCount    = r_retireCount;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage. Directed scenarios
//                followed by randomized traffic, compared against a
//                behavioural model of the stage contents and retire count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_writeback_stage;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memToReg;
        logic        link;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  addr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  wr;
    } inst_t;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        Flush;
    inst_t       drv;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWriteSignal;
    logic        FwdValid;
    logic        AlignError;
    logic [31:0] RetireCount;

    writeback_stage dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (Stall),
        .Flush          (Flush),
        .InValid        (drv.valid),
        .InRegWrite     (drv.regWrite),
        .InMemToReg     (drv.memToReg),
        .InLink         (drv.link),
        .InLoadSize     (drv.size),
        .InLoadSigned   (drv.sgn),
        .InAddrLow      (drv.addr),
        .InAluResult    (drv.alu),
        .InMemData      (drv.mem),
        .InPcPlus4      (drv.pc),
        .InWriteReg     (drv.wr),
        .WriteReg       (WriteReg),
        .WriteData      (WriteData),
        .RegWriteSignal (RegWriteSignal),
        .FwdValid       (FwdValid),
        .AlignError     (AlignError),
        .RetireCount    (RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register file fed by the DUT's write port.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (RegWriteSignal) rf[WriteReg] <= WriteData;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    inst_t       mHeld;
    logic [31:0] mCount;
    bit          mZero;      // fields known to be zero (just reset)
    int          nChecks = 0;
    int          nPass   = 0;

    function automatic logic [31:0] expData(inst_t i);
        logic [31:0] v;
        if (i.link)      return i.pc;
        if (!i.memToReg) return i.alu;
        if (i.size == 2'd2) begin
            v = (i.mem >> (8 * i.addr)) & 32'hFF;
            if (i.sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (i.size == 2'd1) begin
            v = (i.addr >= 2'd2) ? (i.mem >> 16) : (i.mem & 32'hFFFF);
            if (i.sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
            return v;
        end
        return i.mem;
    endfunction

    function automatic bit expAlign(inst_t i);
        if (!i.valid || !i.memToReg) return 1'b0;
        if (i.size == 2'd2) return 1'b0;
        if (i.size == 2'd1) return (i.addr % 2) == 1;
        return i.addr != 0;
    endfunction

    function automatic logic [4:0] expDest(inst_t i);
        return i.link ? 5'd31 : i.wr;
    endfunction

    function automatic bit expWrite(inst_t i);
        return i.valid && (i.regWrite || i.link) && !expAlign(i) && (expDest(i) != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".we"},    32'(RegWriteSignal), 32'(expWrite(mHeld)));
        chk({tag, ".fwd"},   32'(FwdValid),       32'(expWrite(mHeld)));
        chk({tag, ".align"}, 32'(AlignError),     32'(expAlign(mHeld)));
        chk({tag, ".count"}, RetireCount,         mCount);
        if (mHeld.valid || mZero) begin
            chk({tag, ".dest"}, 32'(WriteReg), 32'(expDest(mHeld)));
            chk({tag, ".data"}, WriteData,     expData(mHeld));
        end
    endtask

    task automatic modelReset();
        mHeld  = '0;
        mCount = 32'd0;
        mZero  = 1'b1;
    endtask

    // One clock edge: update the model from the inputs present at the edge,
    // then return on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        if (mHeld.valid && (Flush || !Stall)) mCount = mCount + 32'd1;
        if (Flush) begin
            mHeld.valid = 1'b0;
            mZero       = 1'b0;
        end else if (!Stall) begin
            mHeld = drv;
            mZero = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic inst_t mkInst(logic rw, logic m2r, logic lnk, logic [1:0] sz,
                                     logic sg, logic [1:0] ad, logic [31:0] alu,
                                     logic [31:0] mem, logic [31:0] pc, logic [4:0] wr);
        inst_t i;
        i.valid = 1'b1; i.regWrite = rw; i.memToReg = m2r; i.link = lnk;
        i.size = sz; i.sgn = sg; i.addr = ad; i.alu = alu; i.mem = mem; i.pc = pc; i.wr = wr;
        return i;
    endfunction

    initial begin
        rst   = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        drv   = '0;
        modelReset();
        #1;
        checkAll("reset");
        #1 rst = 1'b0;
        @(negedge clk);

        // ALU result write, then register-file commit on the following edge
        drv = mkInst(1, 0, 0, 2'd0, 0, 2'd0, 32'd17697, 32'h0, 32'h0, 5'd17);
        step();
        checkAll("alu");
        chk("alu.dataConst", WriteData, 32'd17697);
        drv = '0;
        step();
        chk("alu.rf17", rf[17], 32'd17697);

        // Byte loads, signed and unsigned
        drv = mkInst(1, 1, 0, 2'd2, 1, 2'd1, 32'h0, 32'h123480FF, 32'h0, 5'd8);
        step();
        checkAll("byteS");
        chk("byteS.const", WriteData, 32'hFFFFFF80);
        drv.sgn = 1'b0;
        step();
        checkAll("byteU");
        chk("byteU.const", WriteData, 32'h00000080);

        // Half loads: aligned signed, then misaligned
        drv = mkInst(1, 1, 0, 2'd1, 1, 2'd2, 32'h0, 32'h8001ABCD, 32'h0, 5'd9);
        step();
        checkAll("halfS");
        chk("halfS.const", WriteData, 32'hFFFF8001);
        drv.addr = 2'd1;
        step();
        checkAll("halfMis");
        chk("halfMis.alignConst", 32'(AlignError), 32'd1);
        drv = '0;
        step();
        checkAll("halfMis.retired");

        // JAL link write
        drv = mkInst(0, 0, 1, 2'd0, 0, 2'd0, 32'hDEAD, 32'h0, 32'h00400010, 5'd5);
        step();
        checkAll("jal");
        chk("jal.destConst", 32'(WriteReg), 32'd31);

        // Write to $0 is suppressed
        drv = mkInst(1, 0, 0, 2'd0, 0, 2'd0, 32'h55, 32'h0, 32'h0, 5'd0);
        step();
        checkAll("zeroDest");

        // Stall for three cycles with a different instruction pending
        drv = mkInst(1, 0, 0, 2'd0, 0, 2'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd12);
        step();
        checkAll("preStall");
        drv   = mkInst(1, 0, 0, 2'd0, 0, 2'd0, 32'h11111111, 32'h0, 32'h0, 5'd13);
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkAll("stall");
        end
        Stall = 1'b0;
        step();
        checkAll("release");

        // Flush with Stall: bubble next cycle, held instruction still retires
        Stall = 1'b1;
        Flush = 1'b1;
        step();
        checkAll("flushStall");
        Stall = 1'b0;
        Flush = 1'b0;

        // Asynchronous reset pulse between edges
        drv = mkInst(1, 1, 0, 2'd0, 0, 2'd0, 32'h0, 32'hCAFEF00D, 32'h0, 5'd3);
        step();
        checkAll("preRst");
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll("asyncRst");
        #1 rst = 1'b0;
        step();
        checkAll("recover");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drv.valid    = ($urandom_range(0, 7) != 0);
            drv.regWrite = ($urandom_range(0, 3) != 0);
            drv.memToReg = $urandom_range(0, 1) == 1;
            drv.link     = ($urandom_range(0, 7) == 0);
            drv.size     = 2'($urandom_range(0, 3));
            drv.sgn      = $urandom_range(0, 1) == 1;
            drv.addr     = 2'($urandom_range(0, 3));
            drv.alu      = $urandom;
            drv.mem      = $urandom;
            drv.pc       = $urandom;
            drv.wr       = 5'($urandom_range(0, 31));
            Stall        = ($urandom_range(0, 3) == 0);
            Flush        = ($urandom_range(0, 7) == 0);
            step();
            checkAll("rand");
        end
        Stall = 1'b0;
        Flush = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
